// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer between the I-cache and the instruction realigner: owns the fetch PC,
// issues one block request at a time, forwards responses and holds one under back-pressure.
module fetch_seq_ctrl #(
  parameter int unsigned VLEN        = 64,
  parameter int unsigned FETCH_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [VLEN-1:0]        boot_addr_i,
  input  logic                   flush_i,
  input  logic                   redirect_valid_i,
  input  logic [VLEN-1:0]        redirect_addr_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [VLEN-1:0]        req_addr_o,
  output logic                   req_kill_o,
  input  logic                   rsp_valid_i,
  input  logic [FETCH_WIDTH-1:0] rsp_data_i,
  input  logic                   queue_ready_i,
  output logic                   fetch_valid_o,
  output logic [VLEN-1:0]        fetch_addr_o,
  output logic [FETCH_WIDTH-1:0] fetch_data_o,
  output logic                   realign_flush_o
);
  localparam int unsigned FB = FETCH_WIDTH / 8;
  localparam int unsigned LB = $clog2(FB);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [VLEN-1:0]        pc_q, pc_d;
  logic [VLEN-1:0]        out_addr_q, out_addr_d;
  logic [FETCH_WIDTH-1:0] hold_q, hold_d;
  logic [VLEN-1:0]        redir_tgt, pc_inc;
  logic                   stop;

  // Targets are halfword aligned; the increment realigns to the next block boundary.
  assign redir_tgt = redirect_addr_i & ~VLEN'(1);
  assign pc_inc    = {pc_q[VLEN-1:LB], {LB{1'b0}}} + VLEN'(FB);
  assign stop      = flush_i | redirect_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      out_addr_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_addr_q <= out_addr_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_addr_d = out_addr_q;
    hold_d     = hold_q;
    case (state_q)
      BOOT: begin
        if (flush_i) begin
          pc_d    = boot_addr_i;
          state_d = IDLE;
        end else if (redirect_valid_i) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else begin
          pc_d    = boot_addr_i;
          state_d = REQ;
        end
      end
      IDLE: begin
        if (!flush_i && redirect_valid_i) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (redirect_valid_i) begin
          pc_d = redir_tgt;
        end else if (req_ready_i) begin
          out_addr_d = pc_q;
          pc_d       = pc_inc;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (redirect_valid_i) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (rsp_valid_i) begin
          if (queue_ready_i) begin
            state_d = REQ;
          end else begin
            hold_d  = rsp_data_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (redirect_valid_i) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (queue_ready_i) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    req_valid_o     = 1'b0;
    req_kill_o      = 1'b0;
    fetch_valid_o   = 1'b0;
    fetch_data_o    = '0;
    req_addr_o      = pc_q;
    fetch_addr_o    = out_addr_q;
    realign_flush_o = stop;
    case (state_q)
      REQ:  req_valid_o = 1'b1;
      WAIT: begin
        // A kill drops any same-cycle response; the cache sends nothing afterwards.
        req_kill_o    = stop;
        fetch_valid_o = rsp_valid_i & queue_ready_i & ~stop;
        fetch_data_o  = rsp_data_i;
      end
      HOLD: begin
        fetch_valid_o = queue_ready_i & ~stop;
        fetch_data_o  = hold_q;
      end
      default: ;
    endcase
  end
endmodule
